ysyx_22040632_divider: RTL and testbench
========================================

// Module: ysyx_22040632_divider
// PURPOSE
//  Iterative radix-2 restoring divider; responder (.div side) of ysyx_22040632_divif.
//  The EXU drives operands and div_valid; this block returns quotient/remainder.
//  Supports 64-bit ops and RV64 W-ops (divw/divuw/remw/remuw), signed and unsigned.
//  Multi-cycle; the EXU stalls until out_valid.
// PARAMETERS
//  XLEN  64  datapath width; W-mode operates on XLEN/2 bits.
// PORTS
//  clk        in   1     clock, rising edge
//  rst        in   1     reset, asynchronous, active-high
//  div_valid  in   1     request valid (level, held by EXU while a div op is in EX)
//  div_ready  out  1     divider can accept a request
//  div_signed in   1     1 = signed (divw/remw); 0 = unsigned
//  divw       in   1     1 = 32-bit W-op; operands use bits [31:0]
//  flush      in   1     abort the in-flight op (pipeline flush)
//  dividend   in   XLEN  dividend
//  divisor    in   XLEN  divisor
//  out_ready  in   1     consumer accepts the result
//  out_valid  out  1     quotient/remainder valid
//  quotient   out  XLEN  quotient; W-mode result sign-extended from bit 31
//  remainder  out  XLEN  remainder; W-mode result sign-extended from bit 31
// BEHAVIOUR
//  Reset: state=IDLE; div_ready=1; out_valid=0; quotient=0; remainder=0; counter=0.
//  FSM states IDLE -> CALC -> DONE -> IDLE.
//   IDLE: div_ready=1. If div_valid, latch the operands as magnitudes, the result signs,
//    and the width mode, then go to CALC. div_ready drops in the next cycle.
//   CALC: one quotient bit per cycle, MSB first. 64 cycles in 64-bit mode, 32 in W-mode.
//    Iteration: rem={rem,q_msb}; if rem>=dvs then rem-=dvs and the bit is 1.
//    After the last bit, apply the signs: q negated iff signs differ; r takes the
//    dividend's sign. Go to DONE.
//   DONE: out_valid=1, results stable. If out_ready, go to IDLE on the same edge.
//  Latency: 64-bit mode, accept edge to out_valid = 65 cycles; W-mode = 33 cycles.
//  Handshake: a request fires only on div_valid&&div_ready; at most one op in flight.
//  Operands are sampled once; input changes after accept are ignored.
//  W-mode extension: signed ops sign-extend [31:0] to 64 bits, unsigned ops zero-extend.
//  W-mode outputs are {{32{r[31]}},r[31:0]} for both signed and unsigned ops.
//  Divide by zero: result valid after 1 cycle of CALC.
//   q = all ones in the active width, sign-extended.
//   r = dividend in the active width, sign-extended.
//  Signed overflow (MIN / -1): q = MIN, r = 0, after 1 cycle of CALC.
//  flush in any state: go to IDLE next edge, out_valid=0, no result produced.
//  flush has priority over div_valid and out_ready in the same cycle.
//  In IDLE, flush && div_valid: the request is NOT accepted.
//  rst mid-operation: immediate return to the reset values; the op is lost.
//  The counter never wraps; CALC exits when the counter reaches its terminal count.
// CONFIGURATION
//  YSYX_22040632_DIV_EARLY_OUT_EN
//   Defined: dividend==0 finishes in 1 CALC cycle (q=0, r=0).
//    CALC also skips leading-zero dividend bits: start at the first set bit, counted in
//    groups of 8 bits. Latency varies from 2 to 65 cycles.
//   Undefined: fixed latency (65/33), except for divide-by-zero and overflow.
// STRUCTURE
//  Shared package ysyx_22040632_RISCV_PKG:
//   div_state_e {IDLE,CALC,DONE}, DIV_CNT_W=7, DIV_W_BITS=32.
//  Sub-module ysyx_22040632_div_signfix (combinational):
//   abs-value input conditioning and output sign restoration.
//  Top level: FSM, counter, and the rem/quot shift registers.
// TESTING
//  1. 64-bit unsigned 100/7 -> out_valid at cycle 65, q=14, r=2; div_ready=0 while busy.
//  2. divw signed -7/2 (0xFFFFFFF9, 2) -> q=0xFFFFFFFFFFFFFFFD (-3), r=0xFFFFFFFFFFFFFFFF (-1),
//     latency 33.
//  3. divuw 0x80000000/1 -> q=0xFFFFFFFF80000000 (sign-extended), r=0.
//  4. Divide by zero 64-bit 5/0 -> q=0xFFFFFFFFFFFFFFFF, r=5, out_valid 2 cycles after accept.
//  5. Signed 0x8000000000000000 / -1 -> q=0x8000000000000000, r=0.
//  6. flush at CALC cycle 10 -> IDLE next edge, no out_valid.
//     Hold out_ready=0 in DONE -> results stable until out_ready.
//     Assert rst mid-CALC -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/ysyx_22040632_divider_pkg.sv
// ysyx_22040632_RISCV_PKG: divider state type, widths and shared helpers.
package ysyx_22040632_RISCV_PKG;
  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_e;
  localparam int DIV_CNT_W = 7;
  localparam int DIV_W_BITS = 32;
  function automatic logic [63:0] wext(input logic [63:0] x, input logic w);
    return w ? {{32{x[31]}}, x[31:0]} : x;
  endfunction
  function automatic logic [3:0] lead_zero_bytes(input logic [63:0] x);
    logic [3:0] n;
    logic hit;
    n = '0;
    hit = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      hit = hit | (|x[i*8+:8]);
      n = n + {3'b000, !hit};
    end
    return n;
  endfunction
endpackage

// File: rtl/ysyx_22040632_div_signfix.sv
// ysyx_22040632_div_signfix: operand magnitudes for the divider and sign restoration of its results.
module ysyx_22040632_div_signfix
  import ysyx_22040632_RISCV_PKG::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            sgn_i,
  input  logic            w_i,
  output logic [XLEN-1:0] a_mag_o,
  output logic [XLEN-1:0] b_mag_o,
  output logic            a_neg_o,
  output logic            b_neg_o,
  input  logic [XLEN-1:0] q_mag_i,
  input  logic [XLEN-1:0] r_mag_i,
  input  logic            neg_q_i,
  input  logic            neg_r_i,
  input  logic            wr_i,
  output logic [XLEN-1:0] q_o,
  output logic [XLEN-1:0] r_o
);
  localparam int H = XLEN / 2;
  logic [XLEN-1:0] a_ext, b_ext;
  assign a_ext   = w_i ? {{H{a_i[H-1] & sgn_i}}, a_i[H-1:0]} : a_i;
  assign b_ext   = w_i ? {{H{b_i[H-1] & sgn_i}}, b_i[H-1:0]} : b_i;
  assign a_neg_o = sgn_i & a_ext[XLEN-1];
  assign b_neg_o = sgn_i & b_ext[XLEN-1];
  assign a_mag_o = a_neg_o ? -a_ext : a_ext;
  assign b_mag_o = b_neg_o ? -b_ext : b_ext;
  assign q_o     = wext(neg_q_i ? -q_mag_i : q_mag_i, wr_i);
  assign r_o     = wext(neg_r_i ? -r_mag_i : r_mag_i, wr_i);
endmodule

// File: rtl/ysyx_22040632_divider.sv
// ysyx_22040632_divider: iterative radix-2 restoring divider for 64-bit and W ops, signed/unsigned.
// Optional YSYX_22040632_DIV_EARLY_OUT_EN skips leading zero dividend bytes and zero dividends.
module ysyx_22040632_divider
  import ysyx_22040632_RISCV_PKG::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            div_valid,
  output logic            div_ready,
  input  logic            div_signed,
  input  logic            divw,
  input  logic            flush,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  div_state_e state_q;
  logic [XLEN-1:0] rem_q, quot_q, dvs_q, quo_q, rmd_q;
  logic [XLEN-1:0] rem_d, quot_d, a_mag, b_mag, fq, fr, sa, lq, lr;
  logic [DIV_CNT_W-1:0] cnt_q, cnt0, term;
  logic [XLEN:0] sh;
  logic ge, a_neg, b_neg, nq_q, nr_q, w_q, sp_q, rdy_q, vld_q, dz, ovf, sp;
  ysyx_22040632_div_signfix #(.XLEN(XLEN)) u_signfix (
    .a_i(dividend), .b_i(divisor), .sgn_i(div_signed), .w_i(divw),
    .a_mag_o(a_mag), .b_mag_o(b_mag), .a_neg_o(a_neg), .b_neg_o(b_neg),
    .q_mag_i(quot_d), .r_mag_i(rem_d), .neg_q_i(nq_q), .neg_r_i(nr_q), .wr_i(w_q),
    .q_o(fq), .r_o(fr)
  );
  always_comb begin
    sh     = {rem_q, quot_q[XLEN-1]};
    ge     = sh >= {1'b0, dvs_q};
    rem_d  = ge ? sh[XLEN-1:0] - dvs_q : sh[XLEN-1:0];
    quot_d = {quot_q[XLEN-2:0], ge};
    term   = w_q ? DIV_CNT_W'(DIV_W_BITS) : DIV_CNT_W'(XLEN);
    dz     = b_mag == '0;
    ovf    = a_neg && b_neg && b_mag == XLEN'(1) && a_mag == XLEN'(1) << (divw ? XLEN/2-1 : XLEN-1);
    // W operands are aligned to the top so the MSB-first shift starts at bit 31
    sa     = divw ? a_mag << (XLEN/2) : a_mag;
`ifdef YSYX_22040632_DIV_EARLY_OUT_EN
    sp     = dz | ovf | (a_mag == '0);
    cnt0   = {lead_zero_bytes(sa), 3'b000};
`else
    sp     = dz | ovf;
    cnt0   = '0;
`endif
    lq     = dz ? '1 : ovf ? dividend : '0;
    lr     = dz ? dividend : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvs_q   <= '0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
      w_q     <= 1'b0;
      sp_q    <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (div_valid) begin
          state_q <= CALC;
          rdy_q   <= 1'b0;
          w_q     <= divw;
          nq_q    <= a_neg ^ b_neg;
          nr_q    <= a_neg;
          sp_q    <= sp;
          dvs_q   <= b_mag;
          cnt_q   <= cnt0;
          quot_q  <= sp ? lq : sa << cnt0;
          rem_q   <= sp ? lr : '0;
        end
        CALC: if (sp_q) begin
          quo_q   <= wext(quot_q, w_q);
          rmd_q   <= wext(rem_q, w_q);
          vld_q   <= 1'b1;
          state_q <= DONE;
        end else begin
          rem_q  <= rem_d;
          quot_q <= quot_d;
          cnt_q  <= cnt_q + DIV_CNT_W'(1);
          if (cnt_q + DIV_CNT_W'(1) == term) begin
            quo_q   <= fq;
            rmd_q   <= fr;
            vld_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: if (out_ready) begin
          state_q <= IDLE;
          vld_q   <= 1'b0;
          rdy_q   <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign div_ready = rdy_q;
  assign out_valid = vld_q;
  assign quotient  = quo_q;
  assign remainder = rmd_q;
endmodule

// File: tb/tb_ysyx_22040632_divider.sv
// tb_ysyx_22040632_divider: directed and random checks of the divider against an arithmetic model.
module tb_ysyx_22040632_divider;
  logic clk = 1'b0, rst = 1'b1, div_valid = 1'b0, div_signed = 1'b0, divw = 1'b0;
  logic flush = 1'b0, out_ready = 1'b0, div_ready, out_valid;
  logic [63:0] dividend = '0, divisor = '0, quotient, remainder;
  int n_tests = 0, n_fail = 0;

  ysyx_22040632_divider #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .div_valid(div_valid), .div_ready(div_ready),
    .div_signed(div_signed), .divw(divw), .flush(flush),
    .dividend(dividend), .divisor(divisor), .out_ready(out_ready),
    .out_valid(out_valid), .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic s,
                                input logic w, output logic [63:0] q, output logic [63:0] r,
                                output int lat);
    logic [63:0] m;
    logic special;
    int bits;
    if (w) begin
      logic [31:0] a32, b32, q32, r32;
      a32 = a[31:0];
      b32 = b[31:0];
      special = (b32 == 0) || (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF);
      if (b32 == 0) begin q32 = 32'hFFFF_FFFF; r32 = a32; end
      else if (special) begin q32 = a32; r32 = 0; end
      else if (s) begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
      else begin q32 = a32 / b32; r32 = a32 % b32; end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
      m = {32'b0, a32};
      if (s && a32[31]) m = 64'h1_0000_0000 - m;
      lat = 33;
    end else begin
      special = (b == 0) || (s && a == 64'h8000_0000_0000_0000 && b == '1);
      if (b == 0) begin q = '1; r = a; end
      else if (special) begin q = a; r = 0; end
      else if (s) begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
      else begin q = a / b; r = a % b; end
      m = (s && a[63]) ? 64'd0 - a : a;
      lat = 65;
    end
`ifdef YSYX_22040632_DIV_EARLY_OUT_EN
    bits = 0;
    while (m != 0) begin m = m >> 1; bits++; end
    lat = (bits == 0) ? 2 : 8 * ((bits + 7) / 8) + 1;
`endif
    if (special) lat = 2;
  endfunction

  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w,
                       input bit hold, input string tag);
    logic [63:0] eq, er;
    int el, lat;
    model(a, b, s, w, eq, er, el);
    dividend = a; divisor = b; div_signed = s; divw = w; div_valid = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0; dividend = ~a; divisor = {$urandom, $urandom}; div_signed = ~s; divw = ~w;
    chk({tag, ".busy"}, {63'b0, div_ready}, 64'd0);
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk({tag, ".lat"}, 64'(lat), 64'(el));
    chk({tag, ".q"}, quotient, eq);
    chk({tag, ".r"}, remainder, er);
    if (hold) begin
      repeat (3) @(posedge clk);
      #1;
      chk({tag, ".holdv"}, {63'b0, out_valid}, 64'd1);
      chk({tag, ".holdq"}, quotient, eq);
      chk({tag, ".holdr"}, remainder, er);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".drop"}, {62'b0, out_valid, div_ready}, 64'd1);
  endtask

  task automatic no_result(input string tag);
    int seen;
    seen = 0;
    repeat (80) begin @(posedge clk); #1; seen += int'(out_valid); end
    chk({tag, ".noval"}, 64'(seen), 64'd0);
    chk({tag, ".idle"}, {63'b0, div_ready}, 64'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst", {div_ready, out_valid, 2'b0, 60'b0}, {1'b1, 63'b0});
    chk("rst.q", quotient, 64'd0);
    chk("rst.r", remainder, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b0, "t1");
    do_op(64'hFFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b0, "t2");
    do_op(64'h8000_0000, 64'd1, 1'b0, 1'b1, 1'b0, "t3");
    do_op(64'd5, 64'd0, 1'b0, 1'b0, 1'b0, "t4");
    do_op(64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, 1'b1, "t5");
    do_op(64'hDEAD_0000_8000_0000, 64'h1234_FFFF_FFFF, 1'b1, 1'b1, 1'b0, "wovf");
    do_op(64'h0_8000_0001, 64'hAB_0000_0000, 1'b0, 1'b1, 1'b0, "wdz");
    do_op(64'd0, 64'd9, 1'b1, 1'b0, 1'b0, "zero");
    do_op(-64'd1000, 64'd33, 1'b1, 1'b0, 1'b1, "neg64");
    dividend = 64'd12345; divisor = 64'd3; div_signed = 1'b0; divw = 1'b0; div_valid = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush.calc", {62'b0, out_valid, div_ready}, 64'd1);
    no_result("flush");
    flush = 1'b1; div_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; div_valid = 1'b0;
    chk("flushreq", {63'b0, div_ready}, 64'd1);
    no_result("flushreq");
    dividend = 64'd100; divisor = 64'd7; div_valid = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst", {62'b0, div_ready, out_valid}, 64'd2);
    chk("midrst.q", quotient, 64'd0);
    chk("midrst.r", remainder, 64'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    do_op(64'd77, 64'd10, 1'b0, 1'b0, 1'b0, "after");
    for (int i = 0; i < 40; i++) begin
      logic [63:0] a, b;
      a = {$urandom, $urandom} >> $urandom_range(0, 63);
      b = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) a = -a;
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 7) == 0) b = '1;
      do_op(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), (i % 8) == 0,
            $sformatf("rnd%0d", i));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
